// File: rtl/csr_hpm_pkg.sv
// Shared CSR addresses, event-selector register type and address helpers
// for the machine-mode counter/performance-monitor block.
package csr_hpm_pkg;

    localparam logic [11:0] csr_mcycle            = 12'hB00;
    localparam logic [11:0] csr_minstret          = 12'hB02;
    localparam logic [11:0] csr_mcycleh           = 12'hB80;
    localparam logic [11:0] csr_minstreth         = 12'hB82;
    localparam logic [11:0] csr_mcountinhibit     = 12'h320;
    localparam logic [11:0] csr_mhpmevent_base    = 12'h323;
    localparam logic [11:0] csr_mhpmcounter_base  = 12'hB03;
    localparam logic [11:0] csr_mhpmcounterh_base = 12'hB83;

    typedef struct packed {
        logic       of;
        logic [7:0] sel;
    } hpm_event_reg_type;

    localparam hpm_event_reg_type hpm_event_reg_init = '{of: 1'b0, sel: 8'h00};

    // Counter slot k: 0 = mcycle, 1 = minstret, 2.. = mhpmcounter3..
    function automatic logic [11:0] cnt_lo_addr(int k);
        if (k == 0) return csr_mcycle;
        if (k == 1) return csr_minstret;
        return csr_mhpmcounter_base + 12'(k - 2);
    endfunction

    function automatic logic [11:0] cnt_hi_addr(int k);
        if (k == 0) return csr_mcycleh;
        if (k == 1) return csr_minstreth;
        return csr_mhpmcounterh_base + 12'(k - 2);
    endfunction

endpackage

// File: rtl/csr_hpm_if.sv
// CSR read/write port between the machine CSR file and the counter block.
interface csr_hpm_if;
    logic        rden;
    logic [11:0] raddr;
    logic [31:0] rdata;
    logic        rhit;
    logic        wren;
    logic [11:0] waddr;
    logic [31:0] wdata;

    modport master (output rden, raddr, wren, waddr, wdata, input rdata, rhit);
    modport slave  (input rden, raddr, wren, waddr, wdata, output rdata, rhit);
endinterface

// File: rtl/csr_hpm_counter.sv
// One CW-bit counter with split 32-bit low/high CSR write and wrap detect.
module hpm_counter
    import csr_hpm_pkg::*;
#(
    parameter int CW = 64
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          inc,
    input  logic          wr_lo,
    input  logic          wr_hi,
    input  logic [31:0]   wdata,
    output logic [CW-1:0] cnt,
    output logic          wrap
);

    logic [CW-1:0] cnt_q, cnt_d;

    // A CSR write owns the cycle: the other half holds and no increment happens.
    always_comb begin
        cnt_d = cnt_q;
        wrap  = 1'b0;
        if (wr_lo) begin
            cnt_d[31:0] = wdata;
        end else if (wr_hi) begin
            cnt_d[CW-1:32] = wdata[CW-33:0];
        end else if (inc) begin
            cnt_d = cnt_q + CW'(1);
            wrap  = &cnt_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/csr_hpm.sv
// Machine counter/performance-monitor CSRs: mcycle, minstret, NCNT hpm
// counters with event selectors, mcountinhibit and overflow interrupt.
module csr_hpm
    import csr_hpm_pkg::*;
#(
    parameter int NCNT = 4,
    parameter int CW   = 64,
    parameter int NEVT = 16
) (
    input  logic            clock,
    input  logic            reset,
    csr_hpm_if.slave        bus,
    input  logic            retire,
    input  logic [NEVT-1:0] events,
    output logic            ovf_irq
);

    localparam int NC = NCNT + 2;
    // Writable inhibit bits: CY (0), IR (2) and HPM 3..3+NCNT-1.
    localparam logic [31:0] INH_MASK = 32'(((64'd1 << (NCNT + 3)) - 64'd8) | 64'd5);

    logic [CW-1:0]     cnt [NC];
    logic [63:0]       cnt_ext [NC];
    logic [NC-1:0]     inc, wr_lo, wr_hi, wrap;
    logic [1:0]        wrap_unused;
    logic [255:0]      evt_pad;
    hpm_event_reg_type evt_q [NCNT];
    hpm_event_reg_type evt_d [NCNT];
    logic [31:0]       inh_q, inh_d;
    logic              ovf_irq_q, ovf_irq_d;
    logic              rhit_c;
    logic [31:0]       rdata_c;

    for (genvar k = 0; k < NC; k++) begin : g_cnt
        hpm_counter #(.CW(CW)) u_cnt (
            .clock (clock),
            .reset (reset),
            .inc   (inc[k]),
            .wr_lo (wr_lo[k]),
            .wr_hi (wr_hi[k]),
            .wdata (bus.wdata),
            .cnt   (cnt[k]),
            .wrap  (wrap[k])
        );
        assign cnt_ext[k] = 64'(cnt[k]);
    end

    // mcycle and minstret carry no overflow flag.
    assign wrap_unused = wrap[1:0];

    // Bit 0 stays zero so sel=0 and sel>NEVT both select a constant-low event.
    always_comb begin
        evt_pad          = '0;
        evt_pad[NEVT:1]  = events;
    end

    always_comb begin
        wr_lo = '0;
        wr_hi = '0;
        for (int k = 0; k < NC; k++) begin
            wr_lo[k] = bus.wren && (bus.waddr == cnt_lo_addr(k));
            wr_hi[k] = bus.wren && (bus.waddr == cnt_hi_addr(k));
        end
    end

    always_comb begin
        inc    = '0;
        inc[0] = ~inh_q[0];
        inc[1] = retire & ~inh_q[2];
        for (int i = 0; i < NCNT; i++) begin
            inc[2+i] = ~inh_q[3+i] & evt_pad[evt_q[i].sel];
        end
    end

    // Overflow set takes priority over a clearing mhpmevent write.
    always_comb begin
        ovf_irq_d = 1'b0;
        for (int i = 0; i < NCNT; i++) begin
            evt_d[i] = evt_q[i];
            if (bus.wren && (bus.waddr == csr_mhpmevent_base + 12'(i))) begin
                evt_d[i].sel = bus.wdata[7:0];
                evt_d[i].of  = bus.wdata[31];
            end
            if (wrap[2+i]) evt_d[i].of = 1'b1;
            ovf_irq_d = ovf_irq_d | evt_q[i].of;
        end
        inh_d = inh_q;
        if (bus.wren && (bus.waddr == csr_mcountinhibit)) inh_d = bus.wdata & INH_MASK;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCNT; i++) evt_q[i] <= hpm_event_reg_init;
            inh_q     <= '0;
            ovf_irq_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCNT; i++) evt_q[i] <= evt_d[i];
            inh_q     <= inh_d;
            ovf_irq_q <= ovf_irq_d;
        end
    end

    always_comb begin
        rhit_c  = 1'b0;
        rdata_c = '0;
        for (int k = 0; k < NC; k++) begin
            if (bus.raddr == cnt_lo_addr(k)) begin
                rhit_c  = 1'b1;
                rdata_c = cnt_ext[k][31:0];
            end
            if (bus.raddr == cnt_hi_addr(k)) begin
                rhit_c  = 1'b1;
                rdata_c = cnt_ext[k][63:32];
            end
        end
        for (int i = 0; i < NCNT; i++) begin
            if (bus.raddr == csr_mhpmevent_base + 12'(i)) begin
                rhit_c  = 1'b1;
                rdata_c = {evt_q[i].of, 23'b0, evt_q[i].sel};
            end
        end
        if (bus.raddr == csr_mcountinhibit) begin
            rhit_c  = 1'b1;
            rdata_c = inh_q;
        end
    end

    assign bus.rhit  = rhit_c;
    assign bus.rdata = bus.rden ? rdata_c : 32'd0;
    assign ovf_irq   = ovf_irq_q;

endmodule

// File: tb/tb_csr_hpm.sv
// Directed bench for csr_hpm with a cycle-level reference model of the
// counter CSRs and literal spot checks.
module tb_csr_hpm;

    localparam int NCNT = 4;
    localparam int CW   = 64;
    localparam int NEVT = 16;
    localparam int NC   = NCNT + 2;
    localparam logic [63:0] CMASK    = {64{1'b1}} >> (64 - CW);
    localparam logic [31:0] INH_IMPL = 32'h0000_007D;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            retire = 1'b0;
    logic [NEVT-1:0] events = '0;
    logic            ovf_irq;

    csr_hpm_if bus();

    csr_hpm #(.NCNT(NCNT), .CW(CW), .NEVT(NEVT)) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .retire  (retire),
        .events  (events),
        .ovf_irq (ovf_irq)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] mc [NC];
    logic [7:0]  msel [NCNT];
    bit          mof [NCNT];
    logic [31:0] minh;
    bit          mirq;
    bit          fire [NC];
    bit          wrapped [NCNT];
    bit          nirq;
    int          idx;

    function automatic logic [11:0] lo_addr(int k);
        case (k)
            0:       return 12'hB00;
            1:       return 12'hB02;
            default: return 12'hB03 + 12'(k - 2);
        endcase
    endfunction

    task automatic model_read(input logic [11:0] a, output bit hit, output logic [31:0] d);
        hit = 0;
        d   = '0;
        for (int k = 0; k < NC; k++) begin
            if (a == lo_addr(k))          begin hit = 1; d = mc[k][31:0];  end
            if (a == lo_addr(k) + 12'h80) begin hit = 1; d = mc[k][63:32]; end
        end
        for (int i = 0; i < NCNT; i++)
            if (a == 12'h323 + 12'(i)) begin hit = 1; d = {mof[i], 23'b0, msel[i]}; end
        if (a == 12'h320) begin hit = 1; d = minh; end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NC; k++) mc[k] = '0;
            for (int i = 0; i < NCNT; i++) begin msel[i] = '0; mof[i] = 0; end
            minh = '0;
            mirq = 0;
        end else begin
            nirq = 0;
            for (int i = 0; i < NCNT; i++) nirq |= mof[i];
            fire[0] = !minh[0];
            fire[1] = retire && !minh[2];
            for (int i = 0; i < NCNT; i++) begin
                idx = int'(msel[i]) - 1;
                fire[2+i] = !minh[3+i] && idx >= 0 && idx < NEVT && events[idx];
                wrapped[i] = 0;
            end
            for (int k = 0; k < NC; k++) begin
                if (bus.wren && bus.waddr == lo_addr(k))
                    mc[k] = {mc[k][63:32], bus.wdata};
                else if (bus.wren && bus.waddr == lo_addr(k) + 12'h80)
                    mc[k] = {bus.wdata, mc[k][31:0]} & CMASK;
                else if (fire[k]) begin
                    mc[k] = (mc[k] + 64'd1) & CMASK;
                    if (k >= 2 && mc[k] == 64'd0) wrapped[k-2] = 1;
                end
            end
            for (int i = 0; i < NCNT; i++) begin
                if (bus.wren && bus.waddr == 12'h323 + 12'(i)) begin
                    msel[i] = bus.wdata[7:0];
                    mof[i]  = bus.wdata[31];
                end
                if (wrapped[i]) mof[i] = 1;
            end
            if (bus.wren && bus.waddr == 12'h320) minh = bus.wdata & INH_IMPL;
            mirq = nirq;
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    bit          e_hit;
    logic [31:0] e_dat;
    always @(negedge clock) begin
        if (!reset) begin
            model_read(bus.raddr, e_hit, e_dat);
            if (!bus.rden) e_dat = '0;
            check("model_rhit", {63'b0, bus.rhit}, {63'b0, e_hit});
            check("model_rdata", {32'b0, bus.rdata}, {32'b0, e_dat});
            check("model_ovf_irq", {63'b0, ovf_irq}, {63'b0, mirq});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        bus.wren  = 1'b1;
        bus.waddr = a;
        bus.wdata = d;
        tick();
        bus.wren  = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
        bus.rden  = 1'b1;
        bus.raddr = a;
        #1;
        check(name, {32'b0, bus.rdata}, {32'b0, exp});
    endtask

    task automatic rd_miss(input logic [11:0] a, input string name);
        bus.rden  = 1'b1;
        bus.raddr = a;
        #1;
        check({name, "_rhit"}, {63'b0, bus.rhit}, 64'd0);
        check({name, "_rdata"}, {32'b0, bus.rdata}, 64'd0);
    endtask

    initial begin
        bus.rden  = 1'b1;
        bus.raddr = 12'hB00;
        bus.wren  = 1'b0;
        bus.waddr = '0;
        bus.wdata = '0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        rd(12'hB00, 32'd0, "reset_mcycle");
        rd(12'hB03, 32'd0, "reset_hpm3");
        check("reset_ovf_irq", {63'b0, ovf_irq}, 64'd0);
        reset = 1'b0;
        bus.raddr = 12'hB00;
        repeat (10) tick();
        rd(12'hB00, 32'd10, "idle_mcycle");
        rd(12'hB02, 32'd0, "idle_minstret");
        check("idle_ovf_irq", {63'b0, ovf_irq}, 64'd0);

        // Event selection
        wr(12'h323, 32'h2);
        events = 16'h0002;
        repeat (5) tick();
        events = 16'h0001;
        repeat (3) tick();
        events = '0;
        rd(12'hB03, 32'd5, "hpm3_count");
        rd(12'h323, 32'h2, "hpm3_sel");

        // Overflow and interrupt
        wr(12'hB03, 32'hFFFF_FFFF);
        wr(12'hB83, 32'hFFFF_FFFF);
        events = 16'h0002;
        tick();
        events = '0;
        rd(12'hB03, 32'd0, "wrap_lo");
        rd(12'hB83, 32'd0, "wrap_hi");
        rd(12'h323, 32'h8000_0002, "wrap_of");
        check("irq_lag", {63'b0, ovf_irq}, 64'd0);
        tick();
        check("irq_set", {63'b0, ovf_irq}, 64'd1);
        wr(12'h323, 32'h2);
        check("irq_hold", {63'b0, ovf_irq}, 64'd1);
        rd(12'h323, 32'h2, "of_cleared");
        tick();
        check("irq_clear", {63'b0, ovf_irq}, 64'd0);

        // Overflow beats a clearing selector write in the same cycle
        wr(12'hB03, 32'hFFFF_FFFF);
        wr(12'hB83, 32'hFFFF_FFFF);
        events = 16'h0002;
        wr(12'h323, 32'h2);
        events = '0;
        rd(12'h323, 32'h8000_0002, "of_wins");
        wr(12'h323, 32'h2);

        // Selector range limits
        wr(12'h324, 32'h11);
        wr(12'h325, 32'h10);
        events = '1;
        repeat (3) tick();
        events = '0;
        rd(12'hB04, 32'd0, "sel_over_nevt");
        rd(12'hB05, 32'd3, "sel_eq_nevt");
        rd(12'hB06, 32'd0, "sel_zero");
        tick();
        rd(12'h324, 32'h11, "sel_readback");

        // Inhibit
        wr(12'hB00, 32'd1000);
        wr(12'h320, 32'h1);
        rd(12'h320, 32'h1, "inh_read");
        repeat (8) tick();
        rd(12'hB00, 32'd1001, "inh_frozen");
        wr(12'h320, 32'h0);
        rd(12'hB00, 32'd1001, "inh_release_edge");
        tick();
        rd(12'hB00, 32'd1002, "inh_resumed");
        wr(12'h320, 32'hFFFF_FFFF);
        rd(12'h320, INH_IMPL, "inh_mask");
        wr(12'h320, 32'h0);

        // Write vs increment on the same counter
        retire = 1'b1;
        wr(12'hB02, 32'd100);
        retire = 1'b0;
        rd(12'hB02, 32'd100, "instret_write_wins");
        retire = 1'b1;
        tick();
        retire = 1'b0;
        rd(12'hB02, 32'd101, "instret_inc");
        wr(12'hB82, 32'h1234_5678);
        rd(12'hB82, 32'h1234_5678, "instret_hi");
        rd(12'hB02, 32'd101, "instret_lo_hold");

        // Unowned addresses and read enable
        wr(12'hB07, 32'h5);
        wr(12'h321, 32'h5);
        rd_miss(12'h327, "miss_event");
        rd_miss(12'hB07, "miss_cnt");
        tick();
        rd_miss(12'hB87, "miss_cnth");
        rd_miss(12'h321, "miss_321");
        bus.rden  = 1'b0;
        bus.raddr = 12'hB02;
        #1;
        check("rden_low_rdata", {32'b0, bus.rdata}, 64'd0);
        check("rden_low_rhit", {63'b0, bus.rhit}, 64'd1);
        bus.rden = 1'b1;
        repeat (3) tick();

        // Asynchronous reset mid-count
        events = 16'h0002;
        tick();
        #2;
        reset = 1'b1;
        rd(12'hB00, 32'd0, "async_mcycle");
        rd(12'hB03, 32'd0, "async_hpm3");
        rd(12'hB82, 32'd0, "async_minstreth");
        check("async_irq", {63'b0, ovf_irq}, 64'd0);
        events = '0;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        rd(12'hB00, 32'd3, "post_reset_mcycle");
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
